// File: rtl/branch_stack_pkg.sv
`default_nettype none
// ============================================================================
// branch_stack_pkg : shared state encodings and default sizes for branch_stack
// Rev 1.0
// ============================================================================
package branch_stack_pkg;

    localparam int BS_DATA_LEN = 8;
    localparam int BS_DEPTH    = 16;

    typedef enum logic [2:0] {
        BS_IDLE = 3'b000,
        BS_PUSH = 3'b001,
        BS_POP  = 3'b010,
        BS_SWAP = 3'b011,
        BS_HOLD = 3'b100
    } bs_state_e;

endpackage
`default_nettype wire

// File: rtl/branch_stack_strobe_edge.sv
`default_nettype none
// ============================================================================
// strobe_edge : sanitises a possibly floating strobe and flags its rising edge
// Rev 1.0
// ============================================================================
module strobe_edge (
    input  logic clk,
    input  logic rstn,
    input  logic strobe_i,
    output logic level_o,
    output logic rise_o
);

    logic level_q;

    // A floating (z) or unknown strobe from the PC counts as inactive.
    assign level_o = (strobe_i === 1'b1);
    assign rise_o  = level_o & ~level_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_o;
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_stack.sv
`default_nettype none
// ============================================================================
// branch_stack : edge-triggered LIFO of branch/return targets beside the PC
// Rev 1.0
// ============================================================================
module branch_stack
    import branch_stack_pkg::*;
#(
    parameter int DATA_LEN = BS_DATA_LEN,
    parameter int DEPTH    = BS_DEPTH
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     en,
    input  logic                     stk_push,
    input  logic                     stk_pop,
    input  logic [DATA_LEN-1:0]      stk_data_in,
    output logic [DATA_LEN-1:0]      stk_data_out,
    output logic [$clog2(DEPTH):0]   stk_count,
    output logic                     stk_full,
    output logic                     stk_empty,
    output logic                     op_done,
    output logic                     ovf_err,
    output logic                     unf_err,
    input  logic                     err_clr
);

    localparam int AW  = $clog2(DEPTH);
    localparam int SPW = AW + 1;

    logic push_lvl, push_rise, pop_lvl, pop_rise;

    strobe_edge u_push_edge (
        .clk      (clk),
        .rstn     (rstn),
        .strobe_i (stk_push),
        .level_o  (push_lvl),
        .rise_o   (push_rise)
    );

    strobe_edge u_pop_edge (
        .clk      (clk),
        .rstn     (rstn),
        .strobe_i (stk_pop),
        .level_o  (pop_lvl),
        .rise_o   (pop_rise)
    );

    bs_state_e           state_q, state_d;
    logic [SPW-1:0]      sp_q, sp_d;
    logic [SPW-1:0]      sp_m1;
    logic [DATA_LEN-1:0] dout_q, dout_d;
    logic                op_done_q, op_done_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic                mem_we;
    logic [DATA_LEN-1:0] mem [DEPTH];

    assign sp_m1     = sp_q - SPW'(1);
    assign stk_full  = (sp_q == SPW'(DEPTH));
    assign stk_empty = (sp_q == '0);

    always_comb begin
        state_d   = state_q;
        sp_d      = sp_q;
        dout_d    = dout_q;
        op_done_d = 1'b0;
        ovf_d     = err_clr ? 1'b0 : ovf_q;
        unf_d     = err_clr ? 1'b0 : unf_q;
        mem_we    = 1'b0;
        case (state_q)
            BS_IDLE: begin
                if (en) begin
                    if (push_rise && pop_rise) begin
                        state_d = BS_SWAP;
                    end else if (push_rise) begin
                        state_d = BS_PUSH;
                    end else if (pop_rise) begin
                        state_d = BS_POP;
                    end
                end
            end
            BS_PUSH: begin
                op_done_d = 1'b1;
                state_d   = BS_HOLD;
                if (!stk_full) begin
                    mem_we = 1'b1;
                    sp_d   = sp_q + SPW'(1);
                end else begin
                    ovf_d = 1'b1;
                end
            end
            BS_POP: begin
                op_done_d = 1'b1;
                state_d   = BS_HOLD;
                if (!stk_empty) begin
                    dout_d = mem[sp_m1[AW-1:0]];
                    sp_d   = sp_m1;
                end else begin
                    unf_d = 1'b1;
                end
            end
            BS_SWAP: begin
                op_done_d = 1'b1;
                state_d   = BS_HOLD;
                dout_d    = stk_data_in;
            end
            BS_HOLD: begin
                // Strobes must both drop before any new edge is serviced.
                if (!push_lvl && !pop_lvl) begin
                    state_d = BS_IDLE;
                end
            end
            default: begin
                state_d = BS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= BS_IDLE;
            sp_q      <= '0;
            dout_q    <= '0;
            op_done_q <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sp_q      <= sp_d;
            dout_q    <= dout_d;
            op_done_q <= op_done_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[sp_q[AW-1:0]] <= stk_data_in;
        end
    end

    // op_done rises together with the updated data/count it announces.
    assign stk_data_out = dout_q;
    assign stk_count    = sp_q;
    assign op_done      = op_done_q;
    assign ovf_err      = ovf_q;
    assign unf_err      = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_stack.sv
`default_nettype none
// ============================================================================
// tb_branch_stack : directed stimulus against a queue-based stack model
// Rev 1.0
// ============================================================================
module tb_branch_stack;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       en = 1'b1;
    logic       stk_push = 1'b0;
    logic       pop_drv = 1'b0;
    logic       pop_float = 1'b1;
    logic [7:0] din = 8'h00;
    logic       err_clr = 1'b0;
    wire        stk_pop;
    wire  [7:0] dout;
    wire  [4:0] count;
    wire        full, empty, op_done, ovf, unf;

    assign stk_pop = pop_float ? 1'bz : pop_drv;

    branch_stack #(.DATA_LEN(8), .DEPTH(16)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .en           (en),
        .stk_push     (stk_push),
        .stk_pop      (stk_pop),
        .stk_data_in  (din),
        .stk_data_out (dout),
        .stk_count    (count),
        .stk_full     (full),
        .stk_empty    (empty),
        .op_done      (op_done),
        .ovf_err      (ovf),
        .unf_err      (unf),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Model: a request seen on a rising strobe completes one cycle later,
    // then nothing new is accepted until both strobes are low.
    logic [7:0] q[$];
    logic [7:0] m_dout = 8'h00;
    logic       m_ovf = 1'b0, m_unf = 1'b0, m_done = 1'b0;
    logic       m_pp = 1'b0, m_pq = 1'b0;
    logic       ps, po, pr, por;
    int         m_phase = 0;  // 0 ready, 1 completing, 2 waiting for release
    int         m_op = 0;     // 1 push, 2 pop, 3 swap

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q.delete();
            m_dout = 8'h00; m_ovf = 1'b0; m_unf = 1'b0; m_done = 1'b0;
            m_pp = 1'b0; m_pq = 1'b0; m_phase = 0; m_op = 0;
        end else begin
            ps  = (stk_push === 1'b1);
            po  = (stk_pop === 1'b1);
            pr  = ps && !m_pp;
            por = po && !m_pq;
            m_done = 1'b0;
            if (err_clr) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            case (m_phase)
                0: if (en && (pr || por)) begin
                    m_op    = (pr && por) ? 3 : (pr ? 1 : 2);
                    m_phase = 1;
                end
                1: begin
                    if (m_op == 1) begin
                        if (q.size() < 16) q.push_back(din);
                        else m_ovf = 1'b1;
                    end else if (m_op == 2) begin
                        if (q.size() > 0) m_dout = q.pop_back();
                        else m_unf = 1'b1;
                    end else begin
                        m_dout = din;
                    end
                    m_done  = 1'b1;
                    m_phase = 2;
                end
                default: if (!ps && !po) m_phase = 0;
            endcase
            m_pp = ps;
            m_pq = po;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rstn) begin
            check("dout",    {24'd0, dout},    {24'd0, m_dout});
            check("count",   {27'd0, count},   q.size());
            check("full",    {31'd0, full},    {31'd0, (q.size() == 16)});
            check("empty",   {31'd0, empty},   {31'd0, (q.size() == 0)});
            check("op_done", {31'd0, op_done}, {31'd0, m_done});
            check("ovf",     {31'd0, ovf},     {31'd0, m_ovf});
            check("unf",     {31'd0, unf},     {31'd0, m_unf});
            if (op_done) done_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_val(input logic [7:0] v);
        din = v;
        stk_push = 1'b1;
        tick(1);
        stk_push = 1'b0;
        tick(3);
    endtask

    task automatic pop_hold(input int n);
        pop_float = 1'b0;
        pop_drv = 1'b1;
        tick(n);
        pop_drv = 1'b0;
        pop_float = 1'b1;
        tick(3);
    endtask

    int d0;

    initial begin
        #1;
        check("rst_dout",  {24'd0, dout}, 32'h0);
        check("rst_count", {27'd0, count}, 32'h0);
        check("rst_empty", {31'd0, empty}, 32'h1);
        check("rst_flags", {28'd0, full, op_done, ovf, unf}, 32'h0);
        tick(2);
        rstn = 1'b1;
        tick(2);

        // two pushes, then pop held two cycles; data visible in 3rd cycle
        d0 = done_cnt;
        push_val(8'h12);
        push_val(8'h34);
        pop_float = 1'b0;
        pop_drv = 1'b1;
        tick(2);
        check("t1_dout",  {24'd0, dout}, 32'h34);
        check("t1_count", {27'd0, count}, 32'h1);
        pop_float = 1'b1;
        tick(3);
        check("t1_done", done_cnt - d0, 3);

        // long pop: exactly one entry removed, floating afterwards does nothing
        push_val(8'h56);
        push_val(8'h78);
        d0 = done_cnt;
        pop_hold(5);
        tick(4);
        check("t2_count", {27'd0, count}, 32'h2);
        check("t2_dout",  {24'd0, dout}, 32'h78);
        check("t2_done",  done_cnt - d0, 1);

        // fill, overflow, top entry intact, clear
        for (int i = 0; i < 14; i++) push_val(8'h20 + 8'(i));
        check("t3_full", {31'd0, full}, 32'h1);
        push_val(8'hFF);
        check("t3_ovf",   {31'd0, ovf}, 32'h1);
        check("t3_count", {27'd0, count}, 32'd16);
        pop_hold(1);
        check("t3_top", {24'd0, dout}, 32'h2D);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("t3_clr", {31'd0, ovf}, 32'h0);

        // drain, then underflow keeps last data
        for (int i = 0; i < 15; i++) pop_hold(1);
        check("t4_bottom", {24'd0, dout}, 32'h12);
        pop_hold(2);
        check("t4_unf",   {31'd0, unf}, 32'h1);
        check("t4_dout",  {24'd0, dout}, 32'h12);
        check("t4_count", {27'd0, count}, 32'h0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;

        // simultaneous edges swap in the input value
        push_val(8'h01);
        push_val(8'h02);
        din = 8'hA5;
        stk_push = 1'b1;
        pop_float = 1'b0;
        pop_drv = 1'b1;
        tick(2);
        stk_push = 1'b0;
        pop_float = 1'b1;
        tick(2);
        check("t5_dout",  {24'd0, dout}, 32'hA5);
        check("t5_count", {27'd0, count}, 32'h2);
        check("t5_err",   {30'd0, ovf, unf}, 32'h0);

        // disabled edges are dropped; second strobe edge during hold is ignored
        en = 1'b0;
        push_val(8'h99);
        en = 1'b1;
        tick(2);
        check("t6_en", {27'd0, count}, 32'h2);
        d0 = done_cnt;
        din = 8'h44;
        stk_push = 1'b1;
        tick(2);
        pop_float = 1'b0;
        pop_drv = 1'b1;
        tick(2);
        stk_push = 1'b0;
        pop_float = 1'b1;
        tick(3);
        check("t6_hold_cnt",  {27'd0, count}, 32'h3);
        check("t6_hold_done", done_cnt - d0, 1);

        // asynchronous reset while in the push state
        din = 8'h77;
        stk_push = 1'b1;
        @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        check("t7_dout",  {24'd0, dout}, 32'h0);
        check("t7_count", {27'd0, count}, 32'h0);
        check("t7_flags", {28'd0, full, op_done, ovf, unf}, 32'h0);
        tick(1);
        stk_push = 1'b0;
        tick(1);
        rstn = 1'b1;
        tick(2);
        check("t7_empty", {31'd0, empty}, 32'h1);
        pop_hold(1);
        check("t7_unf", {31'd0, unf}, 32'h1);
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_stack.md
Name: branch_stack

Overview:
LIFO storage for branch/return targets. It is the responder to the program counter's stk_push/stk_pop strobes and supplies stk_data_out.
The program counter holds stk_pop high for several cycles and floats it (z) when idle. This block therefore acts on strobe rising edges only, and treats z/x as inactive.
It sits beside the PC inside the cpu top, and the decode/exec path writes it.

Parameters:
DATA_LEN, 8, width of each stored entry and of stk_data_in/stk_data_out
DEPTH, 16, number of entries (power of two, >=2)

Ports:
clk  input  1  clock, rising-edge
rstn  input  1  reset, asynchronous, active-low
en  input  1  block enable; when 0, strobes are ignored and the edge detectors are still updated
stk_push  input  1  push strobe; the rising edge (0->1) requests one push
stk_pop  input  1  pop strobe; the rising edge requests one pop; z/x is treated as 0
stk_data_in  input  DATA_LEN  value pushed
stk_data_out  output  DATA_LEN  registered value of the last popped entry
stk_count  output  $clog2(DEPTH)+1  current number of entries
stk_full  output  1  stk_count==DEPTH
stk_empty  output  1  stk_count==0
op_done  output  1  one-cycle pulse when a push/pop is completed or rejected
ovf_err  output  1  sticky: a push was attempted while full
unf_err  output  1  sticky: a pop was attempted while empty
err_clr  input  1  synchronous clear of ovf_err/unf_err

Behaviour:
- Reset (async, rstn=0): sp=0, stk_data_out=0, op_done=0, ovf_err=0, unf_err=0, push_q=0, pop_q=0, state=IDLE. Memory contents are don't-care.
- Strobe sanitising: push_s = (stk_push===1'b1); pop_s = (stk_pop===1'b1).
- Edge registers push_q/pop_q: push_q<=push_s and pop_q<=push_s's pop counterpart (pop_q<=pop_s) every cycle. Rising edge: push_r = push_s & ~push_q; pop_r = pop_s & ~pop_q.
- FSM states: IDLE, PUSH, POP, SWAP, HOLD.
  - IDLE: leave only when en=1. push_r&pop_r -> SWAP; push_r -> PUSH; pop_r -> POP; otherwise stay.
  - PUSH (1 cycle):
    - If not full: mem[sp]<=stk_data_in, sp<=sp+1.
    - Else: ovf_err<=1, sp unchanged.
    - Either way op_done<=1, then -> HOLD.
  - POP (1 cycle):
    - If not empty: stk_data_out<=mem[sp-1], sp<=sp-1.
    - Else: unf_err<=1, stk_data_out unchanged.
    - Either way op_done<=1, then -> HOLD.
  - SWAP (1 cycle, simultaneous edges): stk_data_out<=stk_data_in, sp unchanged, no error regardless of full/empty, op_done<=1, then -> HOLD.
  - HOLD: stays while push_s|pop_s. Returns to IDLE when both are 0 (or z).
    - A new edge on the other strobe while in HOLD is not serviced. The strobe must drop first.
- Latency: strobe edge at cycle N -> state change at N+1 -> stk_data_out/stk_count valid after the edge ending cycle N+1.
  - Example: a PC that holds pop for 2 cycles sees the new data when it samples in its 3rd cycle.
- op_done is high exactly one cycle per serviced request; it is 0 in IDLE and HOLD.
- stk_data_in is sampled in the PUSH cycle, not at the edge cycle. The driver holds it stable while the strobe is high.
- Pointer width: sp is $clog2(DEPTH)+1 bits. It never wraps; it saturates by rejection at 0 and DEPTH.
- stk_full/stk_empty/stk_count are combinational from sp.
- err_clr=1 clears both sticky flags. If err_clr and a new error occur in the same cycle, the error wins (flag =1).
- Reset mid-operation: immediate return to the reset values; any in-flight push is lost.
- en=0 in IDLE: edges are discarded and no request is queued. en is not sampled in PUSH/POP/SWAP/HOLD.

Decomposition:
- Shared package/include: state encodings (BS_IDLE=3'b000, BS_PUSH=3'b001, BS_POP=3'b010, BS_SWAP=3'b011, BS_HOLD=3'b100) and the defaults for DATA_LEN/DEPTH.
- One natural sub-module: strobe_edge (sanitise + register + rising-edge detect), instantiated twice.
- The memory array is inline regs.

Test Plan:
- Push 8'h12, 8'h34 (one-cycle strobes, gaps) then pop held 2 cycles -> stk_data_out=8'h34 on cycle 3 after the edge, stk_count=1, exactly one op_done pulse per request.
- Pop held high 5 cycles with stk_count=3 -> exactly one pop; stk_count=2; the strobe goes z afterwards with no further pop.
- Fill to DEPTH=16, then push 8'hFF -> stk_full=1, ovf_err=1, stk_count stays 16, top entry unchanged; err_clr -> ovf_err=0.
- Pop on empty -> unf_err=1, stk_data_out keeps the previous value, stk_count=0.
- Push and pop rising in the same cycle with stk_data_in=8'hA5 and count=2 -> stk_data_out=8'hA5, count=2, no error.
- Assert rstn=0 asynchronously during the PUSH state -> all outputs zero immediately; after release, stk_empty=1 and the first pop flags unf_err.
